ct_f_spsram_ctrl_512x144: RTL and testbench

Initiator-side controller that drives the active-low single-port SRAM interface (A/CEN/GWEN/WEN/D/Q) of a 512x144 array from a valid/ready request channel. Converts active-high write masks to per-bit active-low WEN and returns read data on a valid/ready response channel. Read data is held when the consumer back-pressures. Sits between cache/queue logic and the FPGA SRAM macro.

---
 rtl/ct_f_spsram_ctrl_pkg.sv | 16 +
 rtl/ct_f_spsram_ctrl_rsp_hold.sv | 43 ++++
 rtl/ct_f_spsram_ctrl_512x144.sv | 107 ++++++++++
 tb/tb_ct_f_spsram_ctrl_512x144.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared state encoding and constants for the 512x144 single-port SRAM controller.
package ct_f_spsram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 9;
    localparam int SRAM_DATA_W = 144;
    localparam int DEPTH       = 2**SRAM_ADDR_W;

    localparam logic [SRAM_DATA_W-1:0] DATA_ONES  = '1;
    localparam logic [SRAM_DATA_W-1:0] DATA_ZEROS = '0;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ct_f_spsram_ctrl_rsp_hold.sv
// Read-response stage: tracks the SRAM read in flight and parks Q in a hold
// register while the consumer back-pressures.
module ct_f_spsram_ctrl_rsp_hold
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = SRAM_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_acc,
    input  logic                  rsp_rdy,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  stall
);

    logic                  rd_pend;
    logic                  hold_vld;
    logic [DATA_WIDTH-1:0] hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            hold_vld <= 1'b0;
        end else begin
            rd_pend  <= rd_acc;
            hold_vld <= (hold_vld || rd_pend) && !rsp_rdy;
        end
    end

    // Q is only valid for one cycle after the access, so capture it on the first stalled cycle.
    always_ff @(posedge clk) begin
        if (rd_pend && !hold_vld && !rsp_rdy) begin
            hold_q <= sram_q;
        end
    end

    assign rsp_vld   = (rd_pend || hold_vld) && !rst;
    assign rsp_rdata = hold_vld ? hold_q : sram_q;
    assign stall     = hold_vld || (rd_pend && !rsp_rdy);

endmodule

// File: rtl/ct_f_spsram_ctrl_512x144.sv
// Valid/ready front end for a 512x144 active-low single-port SRAM macro.
// Define CT_SPSRAM_CTRL_INIT_EN to zero-sweep the array after every reset.
module ct_f_spsram_ctrl_512x144
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_W,
    parameter int DATA_WIDTH = SRAM_DATA_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    state_t state;
    logic   init_done_r;
    logic   run;
    logic   stall;
    logic   req_acc;

    // Reset is synchronous, so the SRAM strobes and handshakes are also masked
    // combinationally to keep them quiet during the very first reset cycle.
    assign run       = (state == RUN) && !RST;
    assign req_rdy   = run && !stall;
    assign req_acc   = req_vld && req_rdy;
    assign init_done = init_done_r && !RST;

`ifdef CT_SPSRAM_CTRL_INIT_EN
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  sweep;

    assign sweep = (state == INIT) && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= INIT;
            init_cnt    <= '0;
            init_done_r <= 1'b0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
            if (&init_cnt) begin
                state       <= RUN;
                init_done_r <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            init_done_r <= 1'b1;
        end
    end
`endif

    always_comb begin
        sram_a    = req_addr;
        sram_d    = req_wdata;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = DATA_ONES;
        if (req_acc) begin
            sram_cen = 1'b0;
            if (req_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~req_wmask;
            end
        end
`ifdef CT_SPSRAM_CTRL_INIT_EN
        if (sweep) begin
            sram_a    = init_cnt;
            sram_d    = DATA_ZEROS;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = DATA_ZEROS;
        end
`endif
    end

    ct_f_spsram_ctrl_rsp_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_hold (
        .clk       (CLK),
        .rst       (RST),
        .rd_acc    (req_acc && !req_wr),
        .rsp_rdy   (rsp_rdy),
        .sram_q    (sram_q),
        .rsp_vld   (rsp_vld),
        .rsp_rdata (rsp_rdata),
        .stall     (stall)
    );

endmodule

// File: tb/tb_ct_f_spsram_ctrl_512x144.sv
// Self-checking bench: SRAM macro model, transaction-level reference model and directed vectors.
module tb_ct_f_spsram_ctrl_512x144;

    localparam int AW       = 9;
    localparam int DW       = 144;
    localparam int DEPTH_TB = 512;
`ifdef CT_SPSRAM_CTRL_INIT_EN
    localparam int INIT_CYCLES = 512;
`else
    localparam int INIT_CYCLES = 0;
`endif
    localparam logic [DW-1:0] ONES = '1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_vld, req_rdy, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, req_wmask;
    logic          rsp_vld, rsp_rdy;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d, sram_q;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 CLK = ~CLK;

    ct_f_spsram_ctrl_512x144 dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .sram_a    (sram_a),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    // SRAM macro: Q registered one cycle after a read, per-bit active-low write enables.
    logic [DW-1:0] sram_mem [DEPTH_TB];
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= sram_mem[sram_a];
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: expected memory contents plus at most one outstanding response.
    logic [DW-1:0] m_mem [DEPTH_TB];
    bit            m_known [DEPTH_TB];
    int            m_cyc;
    bit            m_has, m_held, m_dknown;
    logic [DW-1:0] m_data;
    bit            m_acc, m_erdy;

    always @(negedge CLK) begin
        if (RST) begin
            chk("rst_cen",  sram_cen, 1'b1);
            chk("rst_gwen", sram_gwen, 1'b1);
            chk("rst_wen",  sram_wen, ONES);
            chk("rst_rdy",  req_rdy, 1'b0);
            chk("rst_vld",  rsp_vld, 1'b0);
            chk("rst_done", init_done, 1'b0);
            m_cyc = 0;
            m_has = 0;
        end else if (m_cyc < INIT_CYCLES) begin
            chk("init_cen",  sram_cen, 1'b0);
            chk("init_gwen", sram_gwen, 1'b0);
            chk("init_wen",  sram_wen, '0);
            chk("init_d",    sram_d, '0);
            chk("init_addr", sram_a, m_cyc);
            chk("init_rdy",  req_rdy, 1'b0);
            chk("init_vld",  rsp_vld, 1'b0);
            chk("init_done", init_done, 1'b0);
            m_mem[m_cyc]   = '0;
            m_known[m_cyc] = 1;
            m_cyc++;
        end else begin
            m_erdy = !m_has || (!m_held && rsp_rdy);
            m_acc  = req_vld && m_erdy;
            chk("done", init_done, 1'b1);
            chk("rdy",  req_rdy, m_erdy);
            chk("vld",  rsp_vld, m_has);
            if (m_has && m_dknown) chk("rdata", rsp_rdata, m_data);
            chk("cen",  sram_cen, !m_acc);
            chk("gwen", sram_gwen, !(m_acc && req_wr));
            chk("wen",  sram_wen, (m_acc && req_wr) ? ~req_wmask : ONES);
            if (m_acc) begin
                chk("addr", sram_a, req_addr);
                if (req_wr) chk("d", sram_d, req_wdata);
            end
            if (m_has) begin
                if (rsp_rdy) m_has = 0;
                else         m_held = 1;
            end
            if (m_acc) begin
                if (req_wr) begin
                    m_mem[req_addr] = (m_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                    if (req_wmask == ONES) m_known[req_addr] = 1;
                end else begin
                    m_has    = 1;
                    m_held   = 0;
                    m_data   = m_mem[req_addr];
                    m_dknown = m_known[req_addr];
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        req_vld   = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
    endtask

    task automatic set_req(input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [17:0] w;
        w = 18'(i * 3 + 1);
        return {8{w}};
    endfunction

    logic [DW-1:0] d1, d7, m8;

    initial begin
        d1 = 144'h0123_0123456789ABCDEF_0123456789ABCDEF;
        d7 = 144'hA5A5_5A5A5A5A5A5A5A5A_C3C3C3C3C3C3C3C3;
        m8 = 144'hFF;
        RST = 1'b1;
        rsp_rdy = 1'b1;
        idle();
        repeat (3) step();
        @(negedge CLK);
        chk("lit_rst_done", init_done, 1'b0);
        chk("lit_rst_cen", sram_cen, 1'b1);
        step();
        RST = 1'b0;
        @(negedge CLK);
`ifdef CT_SPSRAM_CTRL_INIT_EN
        chk("lit_sweep_a0", sram_a, 9'd0);
        chk("lit_sweep_done0", init_done, 1'b0);
        repeat (INIT_CYCLES) step();
        @(negedge CLK);
`endif
        chk("lit_first_done", init_done, 1'b1);
        chk("lit_first_rdy", req_rdy, 1'b1);

        // Full-mask write then read-after-write of the same word
        step(); set_req(1'b1, 9'h1A5, d1, ONES);
        @(negedge CLK);
        chk("lit_wr_gwen", sram_gwen, 1'b0);
        chk("lit_wr_wen", sram_wen, '0);
        chk("lit_wr_a", sram_a, 9'h1A5);
        step(); set_req(1'b0, 9'h1A5, '0, '0);
        @(negedge CLK);
        chk("lit_rd_cen", sram_cen, 1'b0);
        chk("lit_rd_gwen", sram_gwen, 1'b1);
        step(); idle();
        @(negedge CLK);
        chk("lit_rd_vld", rsp_vld, 1'b1);
        chk("lit_rd_data", rsp_rdata, d1);

        // Partial-mask write over a zeroed word; write accepted while the read response is delivered
        step(); set_req(1'b1, 9'd5, '0, ONES);
        step(); set_req(1'b1, 9'd5, ONES, m8);
        @(negedge CLK);
        chk("lit_mask_wen", sram_wen, ~m8);
        step(); set_req(1'b0, 9'd5, '0, '0);
        step(); set_req(1'b1, 9'd6, d1, ONES);
        @(negedge CLK);
        chk("lit_mask_vld", rsp_vld, 1'b1);
        chk("lit_mask_data", rsp_rdata, 144'hFF);
        chk("lit_wr_on_rsp_rdy", req_rdy, 1'b1);

        // Back-pressure: read of 7 held for three cycles while a read of 5 waits
        step(); set_req(1'b1, 9'd7, d7, ONES);
        step(); set_req(1'b0, 9'd7, '0, '0);
        step(); set_req(1'b0, 9'd5, '0, '0); rsp_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("lit_stall_vld", rsp_vld, 1'b1);
            chk("lit_stall_data", rsp_rdata, d7);
            chk("lit_stall_rdy", req_rdy, 1'b0);
            chk("lit_stall_cen", sram_cen, 1'b1);
            if (k < 2) step();
        end
        step(); rsp_rdy = 1'b1;
        @(negedge CLK);
        chk("lit_release_vld", rsp_vld, 1'b1);
        chk("lit_release_data", rsp_rdata, d7);
        chk("lit_release_rdy", req_rdy, 1'b0);
        step();
        @(negedge CLK);
        chk("lit_rdy_back", req_rdy, 1'b1);
        chk("lit_rdy_back_cen", sram_cen, 1'b0);
        step(); idle();
        @(negedge CLK);
        chk("lit_after_stall_data", rsp_rdata, 144'hFF);

        // Eight back-to-back reads
        for (int i = 0; i < 8; i++) begin
            step(); set_req(1'b1, AW'(16 + i), pat(i), ONES);
        end
        for (int i = 0; i < 9; i++) begin
            step();
            if (i < 8) set_req(1'b0, AW'(16 + i), '0, '0);
            else       idle();
            @(negedge CLK);
            if (i < 8) chk("lit_b2b_rdy", req_rdy, 1'b1);
            if (i > 0) begin
                chk("lit_b2b_vld", rsp_vld, 1'b1);
                chk("lit_b2b_data", rsp_rdata, pat(i - 1));
            end
        end
        step();
        @(negedge CLK);
        chk("lit_b2b_end", rsp_vld, 1'b0);

        // Reset while a read is pending drops the response
        step(); set_req(1'b0, 9'd7, '0, '0);
        step(); idle(); RST = 1'b1;
        @(negedge CLK);
        chk("lit_rst_rd_vld", rsp_vld, 1'b0);
        chk("lit_rst_rd_done", init_done, 1'b0);
        step(); RST = 1'b0;
        @(negedge CLK);
        chk("lit_rel_vld", rsp_vld, 1'b0);
`ifdef CT_SPSRAM_CTRL_INIT_EN
        chk("lit_rel_done", init_done, 1'b0);
        repeat (100) step();
        @(negedge CLK);
        chk("lit_mid_a100", sram_a, 9'd100);
        step(); RST = 1'b1;
        step(); RST = 1'b0;
        @(negedge CLK);
        chk("lit_restart_a0", sram_a, 9'd0);
        repeat (511) step();
        @(negedge CLK);
        chk("lit_last_sweep_a", sram_a, 9'd511);
        chk("lit_last_sweep_done", init_done, 1'b0);
        step();
        @(negedge CLK);
        chk("lit_sweep_done", init_done, 1'b1);
        chk("lit_sweep_rdy", req_rdy, 1'b1);
`else
        chk("lit_rel_done", init_done, 1'b1);
`endif
        step(); idle();
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected the bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
